// File: rtl/seq_detector_param.sv
// rtl/seq_detector_param.sv - programmable serial bit-pattern detector with saturating match counter
module seq_detector_param #(
    parameter int                 MAX_LEN     = 8,
    parameter int                 COUNT_W     = 8,
    parameter logic [MAX_LEN-1:0] DEF_PATTERN = MAX_LEN'('h0B),
    parameter int                 DEF_LEN     = 4,
    localparam int                LEN_W       = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               ins,
    input  logic               in_valid,
    input  logic               overlap,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               count_clr,
    output logic               outs,
    output logic [COUNT_W-1:0] match_count,
    output logic               count_sat
);

    localparam logic [LEN_W-1:0]   MAX_LEN_V = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0]   DEF_LEN_V = LEN_W'(DEF_LEN);
    localparam logic [COUNT_W-1:0] COUNT_MAX = '1;

    logic [MAX_LEN-1:0] pattern;
    logic [LEN_W-1:0]   len;
    logic [MAX_LEN-1:0] hist;
    logic [LEN_W-1:0]   fill;

    logic               shift_en;
    logic [MAX_LEN-1:0] hist_shift;
    logic [LEN_W-1:0]   fill_inc;
    logic [MAX_LEN-1:0] len_mask;
    logic               match;
    logic [MAX_LEN-1:0] hist_next;
    logic [LEN_W-1:0]   fill_next;
    logic [LEN_W-1:0]   cfg_len_clamped;
    logic [COUNT_W-1:0] count_inc;
    logic [COUNT_W-1:0] count_next;
    logic               sat_next;

    // Match detection on the post-shift history; fill saturates at MAX_LEN so ARMED persists.
    always_comb begin
        len_mask   = '0;
        shift_en   = in_valid & ~cfg_load;
        hist_shift = {hist[MAX_LEN-2:0], ins};
        fill_inc   = (fill == MAX_LEN_V) ? fill : fill + 1'b1;
        for (int i = 0; i < MAX_LEN; i++) begin
            len_mask[i] = (i < int'(len));
        end
        match = shift_en && (len != '0) && (fill_inc >= len)
                && (((hist_shift ^ pattern) & len_mask) == '0);
    end

    // Next history / fill: cfg_load restarts, a non-overlap match empties the fill.
    always_comb begin
        hist_next       = hist;
        fill_next       = fill;
        cfg_len_clamped = (cfg_len > MAX_LEN_V) ? MAX_LEN_V : cfg_len;
        if (cfg_load) begin
            hist_next = '0;
            fill_next = '0;
        end else if (in_valid) begin
            hist_next = hist_shift;
            fill_next = (match && !overlap) ? '0 : fill_inc;
        end
    end

    // Saturating counter; a clear coinciding with a match leaves that match counted.
    always_comb begin
        count_inc  = match_count + 1'b1;
        count_next = match_count;
        sat_next   = count_sat;
        if (count_clr) begin
            count_next = {{(COUNT_W-1){1'b0}}, match};
            sat_next   = 1'b0;
        end else if (match && match_count != COUNT_MAX) begin
            count_next = count_inc;
            if (count_inc == COUNT_MAX) begin
                sat_next = 1'b1;
            end
        end
    end

    // State registers with synchronous reset restoring the default pattern.
    always_ff @(posedge clk) begin
        if (reset) begin
            pattern     <= DEF_PATTERN;
            len         <= DEF_LEN_V;
            hist        <= '0;
            fill        <= '0;
            outs        <= 1'b0;
            match_count <= '0;
            count_sat   <= 1'b0;
        end else begin
            if (cfg_load) begin
                pattern <= cfg_pattern;
                len     <= cfg_len_clamped;
            end
            hist        <= hist_next;
            fill        <= fill_next;
            outs        <= match;
            match_count <= count_next;
            count_sat   <= sat_next;
        end
    end

endmodule

// File: tb/tb_seq_detector_param.sv
// tb/tb_seq_detector_param.sv - scoreboard bench for seq_detector_param against a bit-queue model
module tb_seq_detector_param;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ins = 1'b0;
    logic       in_valid = 1'b0;
    logic       overlap = 1'b1;
    logic       cfg_load = 1'b0;
    logic [7:0] cfg_pattern = '0;
    logic [3:0] cfg_len = '0;
    logic       count_clr = 1'b0;

    logic       outs_a, outs_b;
    logic [7:0] count_a;
    logic [1:0] count_b;
    logic       sat_a, sat_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seq_detector_param dut_a (
        .clk(clk), .reset(reset), .ins(ins), .in_valid(in_valid), .overlap(overlap),
        .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
        .count_clr(count_clr), .outs(outs_a), .match_count(count_a), .count_sat(sat_a)
    );

    seq_detector_param #(.COUNT_W(2)) dut_b (
        .clk(clk), .reset(reset), .ins(ins), .in_valid(in_valid), .overlap(overlap),
        .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
        .count_clr(count_clr), .outs(outs_b), .match_count(count_b), .count_sat(sat_b)
    );

    // Reference model: the bits received since the last restart, newest at the back.
    bit       m_bits[$];
    bit [7:0] m_pat;
    int       m_len;
    int       m_cnt8, m_cnt2;
    bit       m_sat8, m_sat2;

    typedef struct {
        bit o;
        int c8;
        bit s8;
        int c2;
        bit s2;
    } exp_t;
    exp_t sb[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual %0d required %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Apply the current inputs to the model, queue the expectation, then clock the DUTs.
    task automatic tick();
        bit   m;
        exp_t e;
        m = 1'b0;
        if (reset) begin
            m_pat = 8'h0B;
            m_len = 4;
            m_bits.delete();
            m_cnt8 = 0; m_cnt2 = 0; m_sat8 = 0; m_sat2 = 0;
        end else begin
            if (cfg_load) begin
                m_pat = cfg_pattern;
                m_len = (int'(cfg_len) > 8) ? 8 : int'(cfg_len);
                m_bits.delete();
            end else if (in_valid) begin
                m_bits.push_back(ins);
                if (m_bits.size() > 8) void'(m_bits.pop_front());
                if (m_len != 0 && m_bits.size() >= m_len) begin
                    m = 1'b1;
                    for (int k = 0; k < m_len; k++)
                        if (m_bits[m_bits.size() - 1 - k] != m_pat[k]) m = 1'b0;
                end
                if (m && !overlap) m_bits.delete();
            end
            if (count_clr) begin
                m_cnt8 = m; m_cnt2 = m; m_sat8 = 0; m_sat2 = 0;
            end else if (m) begin
                if (m_cnt8 < 255) m_cnt8++;
                if (m_cnt8 == 255) m_sat8 = 1;
                if (m_cnt2 < 3) m_cnt2++;
                if (m_cnt2 == 3) m_sat2 = 1;
            end
        end
        e.o = m; e.c8 = m_cnt8; e.s8 = m_sat8; e.c2 = m_cnt2; e.s2 = m_sat2;
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0; cfg_load = 1'b0; count_clr = 1'b0; in_valid = 1'b0;
    endtask

    task automatic send(input int n, input logic [31:0] bits);
        logic [31:0] v;
        v = bits;
        for (int i = n - 1; i >= 0; i--) begin
            in_valid = 1'b1;
            ins = v[i];
            tick();
        end
    endtask

    task automatic load(input logic [7:0] p, input int l);
        cfg_load = 1'b1;
        cfg_pattern = p;
        cfg_len = 4'(l);
        tick();
    endtask

    // Monitor: every edge produces a registered output, compared against the queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("outs_a", int'(outs_a), int'(e.o));
                chk("outs_b", int'(outs_b), int'(e.o));
                chk("count_a", int'(count_a), e.c8);
                chk("sat_a", int'(sat_a), int'(e.s8));
                chk("count_b", int'(count_b), e.c2);
                chk("sat_b", int'(sat_b), int'(e.s2));
                if (!in_valid && outs_a && e.o) chk("outs_on_gap", 1, 0);
            end
        end
    end

    initial begin
        @(negedge clk);
        reset = 1'b1; tick();
        reset = 1'b1; tick();
        chk("reset_count", int'(count_a), 0);
        chk("reset_outs", int'(outs_a), 0);

        // Default 1011 overlap stream.
        overlap = 1'b1;
        send(14, 32'b00101110111010);
        chk("t1_count", int'(count_a), 2);

        // Pattern 101, both modes.
        load(8'b101, 3);
        send(5, 32'b10101);
        chk("t2_overlap_count", int'(count_a), 4);
        overlap = 1'b0;
        load(8'b101, 3);
        send(5, 32'b10101);
        chk("t2_nonoverlap_count", int'(count_a), 5);

        // Gaps inside 1011.
        overlap = 1'b1;
        load(8'h0B, 4);
        send(1, 1); tick(); send(2, 2'b01); tick(); tick(); send(1, 1);
        chk("t3_outs", int'(outs_a), 1);

        // Saturation of the 2-bit counter, then clear during a match.
        reset = 1'b1; tick();
        overlap = 1'b0;
        for (int i = 0; i < 5; i++) send(4, 4'b1011);
        chk("t4_count_b", int'(count_b), 3);
        chk("t4_sat_b", int'(sat_b), 1);
        send(3, 3'b101);
        count_clr = 1'b1; in_valid = 1'b1; ins = 1'b1; tick();
        chk("t4_clr_count_b", int'(count_b), 1);
        chk("t4_clr_sat_b", int'(sat_b), 0);

        // Reset mid-pattern.
        overlap = 1'b1;
        send(3, 3'b101);
        reset = 1'b1; tick();
        send(1, 1);
        chk("t5_outs", int'(outs_a), 0);
        chk("t5_count", int'(count_a), 0);

        // Zero length, then an over-length clamp.
        load(8'hFF, 0);
        for (int i = 0; i < 30; i++) send(1, $urandom_range(0, 1));
        chk("t6_len0_count", int'(count_a), 0);
        load(8'hA5, 11);
        send(8, 8'hA5);
        chk("t6_clamp_outs", int'(outs_a), 1);

        // Randomised traffic with short patterns so matches are frequent.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 9) == 0) overlap = $urandom_range(0, 1);
            if ($urandom_range(0, 299) == 0) reset = 1'b1;
            if ($urandom_range(0, 39) == 0) begin
                cfg_load = 1'b1;
                cfg_pattern = 8'($urandom());
                cfg_len = 4'($urandom_range(0, 11) > 6 ? $urandom_range(1, 3) : $urandom_range(0, 11));
            end
            if ($urandom_range(0, 49) == 0) count_clr = 1'b1;
            in_valid = ($urandom_range(0, 3) != 0);
            ins = $urandom_range(0, 1);
            tick();
        end

        tick();
        @(posedge clk);
        #2;
        chk("scoreboard_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
